// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM transmit path.
//   SLOT_BITS / DATA_W : frame geometry (32 slots x 8 bits), fixed by the receiver
//   FRAME_LEN          : bit times per frame
//   slot_t, byte_t     : slot index and slot payload types
//   state_t            : transmitter FSM states
//   parity_of()        : parity bit of one slot byte, even or odd sense
package tdm_pkg;

  localparam int SLOT_BITS = 5;
  localparam int DATA_W    = 8;
  localparam int SLOTS     = 1 << SLOT_BITS;
  localparam int FRAME_LEN = SLOTS * DATA_W;
  localparam int BIT_W     = $clog2(DATA_W);

  typedef logic [SLOT_BITS-1:0] slot_t;
  typedef logic [DATA_W-1:0]    byte_t;
  typedef logic [BIT_W-1:0]     bit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // odd = 0 gives even parity (XOR of the bits), odd = 1 gives its complement.
  function automatic logic parity_of(input byte_t b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/tdm_chan_mem.sv
// Per-timeslot byte store for the TDM source.
//   clk, reset : clock and synchronous active-high clear (all entries -> 8'h00)
//   wr_en      : host write strobe
//   wr_addr    : slot written
//   wr_data    : byte written
//   rd_addr    : slot fetched by the transmitter
//   rd_data    : combinational read; a write to the same slot on the same edge
//                is forwarded so the new byte is the one transmitted
module tdm_chan_mem
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [SLOT_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [SLOT_BITS-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  byte_t mem [SLOTS];

  // NOTE: the memory is cleared by reset because an idle-reset restart must
  // transmit zeros; a plain RAM without this clear would not behave that way.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first bypass: the fetch on a write edge sees the incoming byte.
  always_comb begin
    rd_data = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/tdm_source.sv
// Transmit end of the TDM serial channel.
// Streams frames of 32 slots x 8 bits, MSB first, from a host-written slot memory.
//   clk, reset : clock and synchronous active-high reset
//   en         : run request; a running frame always completes before stopping
//   wr_en, wr_addr, wr_data : host write port into the slot memory
//   err_inj    : inverts the parity of the slot loaded on this edge
//   sdata      : serial data
//   sync       : one-cycle pulse with the MSB of slot 0
//   parity     : parity of the slot on sdata, held for the whole slot
//   slot       : index of the slot on sdata
//   busy       : high while a frame is being transmitted
module tdm_source
  import tdm_pkg::*;
#(
  parameter bit PAR_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [SLOT_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 err_inj,
  output logic                 sdata,
  output logic                 sync,
  output logic                 parity,
  output logic [SLOT_BITS-1:0] slot,
  output logic                 busy
);

  state_t state_q, state_d;
  bit_t   bit_q,   bit_d;
  slot_t  slot_q,  slot_d;
  byte_t  shift_q, shift_d;
  logic   sync_q,  sync_d;
  logic   par_q,   par_d;
  logic   busy_q,  busy_d;

  slot_t  rd_addr;
  byte_t  rd_data;
  logic   load;

  tdm_chan_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    sync_d  = 1'b0;
    par_d   = par_q;
    busy_d  = busy_q;
    load    = 1'b0;
    // The fetch always targets the slot after the current one; 5-bit
    // arithmetic wraps 31 -> 0 for free.
    rd_addr = slot_q + slot_t'(1);

    unique case (state_q)
      IDLE: begin
        rd_addr = '0;
        if (en) begin
          load    = 1'b1;
          state_d = RUN;
          slot_d  = '0;
          sync_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (bit_q == bit_t'(DATA_W - 1)) begin
          bit_d = '0;
          if ((slot_q == slot_t'(SLOTS - 1)) && !en) begin
            // Frame finished and no further run request: back to quiet outputs.
            state_d = IDLE;
            slot_d  = '0;
            shift_d = '0;
            par_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            load   = 1'b1;
            slot_d = slot_q + slot_t'(1);
            sync_d = (slot_q == slot_t'(SLOTS - 1));
          end
        end else begin
          bit_d   = bit_q + bit_t'(1);
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end
      end
    endcase

    if (load) begin
      shift_d = rd_data;
      par_d   = parity_of(rd_data, PAR_ODD) ^ err_inj;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      slot_q  <= '0;
      shift_q <= '0;
      sync_q  <= 1'b0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      sync_q  <= sync_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
    end
  end

  assign sdata  = shift_q[DATA_W-1];
  assign sync   = sync_q;
  assign parity = par_q;
  assign slot   = slot_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_tdm_source.sv
// Self-checking bench for tdm_source: a frame-position reference model, a small
// loopback receiver, directed scenarios and a randomized soak.
module tb_tdm_source;
  import tdm_pkg::*;

  localparam bit PAR_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset, en, wr_en, err_inj;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       sdata, sync, parity, busy;
  logic [4:0] slot;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  always #5 clk = ~clk;

  tdm_source #(.PAR_ODD(PAR_ODD)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .err_inj (err_inj),
    .sdata   (sdata),
    .sync    (sync),
    .parity  (parity),
    .slot    (slot),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position k (0..255) within the running frame; the byte on
  // the wire is whatever was fetched at the start of the current slot.
  logic [7:0] m_mem [32];
  bit         m_run  = 1'b0;
  int         m_k    = 0;
  int         m_ld;
  logic [7:0] m_byte = '0;
  logic       m_inj  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_run  = 1'b0;
      m_k    = 0;
      m_byte = '0;
      m_inj  = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      m_ld = -1;
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_k = 0; m_ld = 0; end
      end else if (m_k == FRAME_LEN - 1) begin
        if (en) begin m_k = 0; m_ld = 0; end
        else m_run = 1'b0;
      end else begin
        m_k++;
        if (m_k % 8 == 0) m_ld = m_k / 8;
      end
      if (m_ld >= 0) begin
        m_byte = (wr_en && (int'(wr_addr) == m_ld)) ? wr_data : m_mem[m_ld];
        m_inj  = err_inj;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  // One compare process, every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sdata",  sdata,  m_run ? m_byte[7 - (m_k % 8)] : 1'b0);
      check("sync",   sync,   m_run && (m_k == 0));
      check("parity", parity, m_run ? ((^m_byte) ^ PAR_ODD ^ m_inj) : 1'b0);
      check("slot",   slot,   m_run ? (m_k / 8) : 0);
      check("busy",   busy,   m_run);
    end
  end

  // Loopback receiver: parity taken in the first bit time of each slot,
  // slot number counted from sync.
  typedef struct {
    int         slot;
    logic [7:0] data;
    logic       par;
    logic       chk;
  } rx_t;

  rx_t        rx_q[$];
  int         sync_cyc[$];
  int         rx_bits = 0;
  int         rx_cnt  = 0;
  logic       rx_par;
  logic [7:0] rx_sh;

  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      rx_bits = 0;
      rx_cnt  = 0;
    end else begin
      if (sync === 1'b1) begin rx_bits = 0; rx_cnt = 0; end
      if (rx_bits == 0) rx_par = parity;
      rx_sh = {rx_sh[6:0], sdata};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_q.push_back('{rx_cnt, rx_sh, rx_par, (^rx_sh) ^ PAR_ODD ^ rx_par});
        rx_bits = 0;
        rx_cnt  = (rx_cnt + 1) % 32;
      end
    end
    if (sync === 1'b1) sync_cyc.push_back(cyc);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    en = 1'b0; wr_en = 1'b0; err_inj = 1'b0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic write(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d;
    cycles(1);
    wr_en = 1'b0;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    sync_cyc.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin cycles(1); n++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_rec(input string name, input int idx, input logic [7:0] data, input logic chk);
    check({name, "_have"}, rx_q.size() > idx, 1'b1);
    if (rx_q.size() > idx) begin
      check({name, "_data"}, rx_q[idx].data, data);
      check({name, "_chk"},  rx_q[idx].chk,  chk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; wr_en = 1'b0; err_inj = 1'b0;
    wr_addr = '0; wr_data = '0;
    cycles(2);
    chk_en = 1'b1;
    check("rst_sdata", sdata, 1'b0);
    check("rst_sync",  sync,  1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_slot",  slot,  5'd0);
    reset = 1'b0;

    // 1: A5 / 01, first two slots with literal expectations.
    do_reset();
    write(0, 8'hA5);
    write(1, 8'h01);
    clear_rx();
    en = 1'b1;
    cycles(1);
    check("t1_sync",  sync,   1'b1);
    check("t1_msb",   sdata,  1'b1);
    check("t1_par0",  parity, 1'b0);
    check("t1_slot0", slot,   5'd0);
    cycles(1);
    check("t1_sync_once", sync, 1'b0);
    cycles(15);
    check("t1_nrec", rx_q.size() >= 2, 1'b1);
    if (rx_q.size() >= 2) begin
      check("t1_bits",  {rx_q[0].data, rx_q[1].data}, 16'hA501);
      check("t1_par",   {rx_q[0].par, rx_q[1].par},   2'b01);
      check("t1_slots", {rx_q[0].slot[4:0], rx_q[1].slot[4:0]}, {5'd0, 5'd1});
    end
    en = 1'b0;
    wait_idle(300);

    // 2: mem[i] = i*7, two frames looped back.
    do_reset();
    for (int i = 0; i < 32; i++) write(i, 8'((i * 7) % 256));
    clear_rx();
    en = 1'b1;
    cycles(1);
    cycles(264);
    en = 1'b0;
    wait_idle(300);
    check("t2_nrec", rx_q.size() >= 64, 1'b1);
    if (rx_q.size() >= 64) begin
      for (int i = 0; i < 64; i++) begin
        check("t2_data", rx_q[i].data, (i % 32) * 7 % 256);
        check("t2_slot", rx_q[i].slot, i % 32);
        check("t2_chk",  rx_q[i].chk,  1'b0);
      end
    end
    check("t2_nsync", sync_cyc.size(), 2);
    if (sync_cyc.size() >= 2) check("t2_period", sync_cyc[1] - sync_cyc[0], 256);

    // 3: write-first on the load edge, and a mid-slot write deferred a frame.
    do_reset();
    clear_rx();
    en = 1'b1;
    cycles(1);
    cycles(39);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hFF;
    cycles(1);
    wr_en = 1'b0;
    cycles(3);
    write(5, 8'h3C);
    cycles(260);
    en = 1'b0;
    wait_idle(300);
    check_rec("t3_s4",  4,  8'h00, 1'b0);
    check_rec("t3_s5",  5,  8'hFF, 1'b0);
    check_rec("t3_s6",  6,  8'h00, 1'b0);
    check_rec("t3_s37", 37, 8'h3C, 1'b0);

    // 4: en dropped in slot 12; frame completes, then restart.
    do_reset();
    write(12, 8'h81);
    write(31, 8'h7E);
    clear_rx();
    en = 1'b1;
    cycles(1);
    cycles(99);
    en = 1'b0;
    wait_idle(300);
    check("t4_nrec",  rx_q.size(), 32);
    check("t4_nsync", sync_cyc.size(), 1);
    check_rec("t4_s31", 31, 8'h7E, 1'b0);
    en = 1'b1;
    cycles(1);
    check("t4_resync", sync, 1'b1);
    check("t4_rebusy", busy, 1'b1);
    en = 1'b0;
    wait_idle(300);

    // 5: reset during slot 10, restart transmits cleared memory.
    do_reset();
    write(0, 8'h5A);
    write(10, 8'hC3);
    en = 1'b1;
    cycles(1);
    cycles(83);
    reset = 1'b1;
    cycles(1);
    check("t5_sdata",  sdata,  1'b0);
    check("t5_sync",   sync,   1'b0);
    check("t5_parity", parity, 1'b0);
    check("t5_slot",   slot,   5'd0);
    check("t5_busy",   busy,   1'b0);
    reset = 1'b0;
    clear_rx();
    cycles(1);
    cycles(88);
    en = 1'b0;
    for (int i = 0; i < 11; i++) check_rec("t5_zero", i, 8'h00, 1'b0);
    wait_idle(300);

    // 6: err_inj on the load of slot 3 only.
    do_reset();
    write(2, 8'h12);
    write(3, 8'h34);
    write(4, 8'h56);
    clear_rx();
    en = 1'b1;
    cycles(1);
    cycles(23);
    err_inj = 1'b1;
    cycles(1);
    err_inj = 1'b0;
    cycles(24);
    en = 1'b0;
    wait_idle(300);
    check_rec("t6_s2", 2, 8'h12, 1'b0);
    check_rec("t6_s3", 3, 8'h34, 1'b1);
    check_rec("t6_s4", 4, 8'h56, 1'b0);

    // Randomized soak against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      err_inj = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      reset   = ($urandom_range(0, 999) == 0);
      cycles(1);
    end
    reset = 1'b0; wr_en = 1'b0; err_inj = 1'b0; en = 1'b0;
    wait_idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
